// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped switch inputs and their conditioning stage.
package io_pkg;

  localparam logic [15:0] SW_ADDR_LO     = 16'hfffe;
  localparam logic [15:0] SW_ADDR_HI     = 16'hffff;
  localparam int          SW_WIDTH       = 16;
  localparam int          DEF_TICK_DIV   = 50000;
  localparam int          DEF_STABLE_CNT = 4;

  // Debounce counter width: enough to hold STABLE_CNT-1, never less than one bit.
  function automatic int cnt_width(input int stable);
    if (stable > 1) begin
      return $clog2(stable);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: two-flop synchroniser, tick-sampled stability counter,
// accepted level and registered rise/fall pulses.
module debounce_bit
  import io_pkg::*;
#(
  parameter int STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sw_raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int             CW      = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CNT - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any tick sample matching the current level restarts the count, so a
  // bounce can never leave a partially accepted transition behind.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level  = level_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign accept = rise_d | fall_d;

endmodule

// File: rtl/switch_debouncer.sv
// Board slide-switch conditioner: shared sample prescaler, per-bit debouncers
// and a software-cleared sticky change flag.
module switch_debouncer
  import io_pkg::*;
#(
  parameter int WIDTH      = SW_WIDTH,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]    pre_q, pre_d;
  logic             tick;
  logic [WIDTH-1:0] accept_s;
  logic             changed_q, changed_d;

  assign tick = (pre_q == PRE_MAX);

  // Set has priority over clear so an event arriving with a clear is kept.
  always_comb begin
    pre_d     = pre_q + PW'(1);
    changed_d = changed_q;
    if (tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end
    if (|accept_s) begin
      changed_d = 1'b1;
    end else if (clr_flag) begin
      changed_d = 1'b0;
    end else begin
      changed_d = changed_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      changed_q <= changed_d;
    end
  end

  assign sw_changed = changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CNT(STABLE_CNT)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .sw_raw(sw_raw[i]),
      .level (switches[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i]),
      .accept(accept_s[i])
    );
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with TICK_DIV=4, STABLE_CNT=3: tick samples
// fall on edges 4, 8, 12, ... after reset release, counted by cyc.
module tb_switch_debouncer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw_raw;
  logic        clr_flag;
  logic [15:0] switches;
  logic [15:0] sw_rise;
  logic [15:0] sw_fall;
  logic        sw_changed;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc;
  int rise_cnt[16];
  int fall_cnt[16];

  switch_debouncer #(
    .WIDTH(16), .TICK_DIV(4), .STABLE_CNT(3)
  ) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .clr_flag(clr_flag),
    .switches(switches), .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic clear_counts();
    for (int i = 0; i < 16; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (sw_rise[i]) rise_cnt[i]++;
      if (sw_fall[i]) fall_cnt[i]++;
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 200) begin
      step();
      guard++;
    end
    tests_run++;
    if (cyc != n) begin
      tests_failed++;
      $display("FAIL wait_cyc: reached cyc %0d, required %0d", cyc, n);
    end
  endtask

  task automatic reset_dut(input logic [15:0] raw);
    @(negedge clk);
    reset    = 1'b0;
    sw_raw   = raw;
    clr_flag = 1'b0;
    clear_counts();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; sw_raw = 16'hffff; clr_flag = 1'b0;
    clear_counts();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({switches, sw_rise, sw_fall, sw_changed} !== 49'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: sw=%h rise=%h fall=%h chg=%b, required all 0",
               switches, sw_rise, sw_fall, sw_changed);
    end
    reset = 1'b1;
    wait_cyc(11);
    tests_run++;
    if (switches !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_hold_early: sw=%h, required 0000", switches);
    end
    wait_cyc(12);
    tests_run++;
    if (switches !== 16'hffff || sw_rise !== 16'hffff || sw_fall !== 16'h0000 || sw_changed !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_accept: sw=%h rise=%h fall=%h chg=%b, required ffff ffff 0000 1",
               switches, sw_rise, sw_fall, sw_changed);
    end
    wait_cyc(13);
    tests_run++;
    if (sw_rise !== 16'h0000 || switches !== 16'hffff) begin
      tests_failed++;
      $display("FAIL reset_pulse_end: sw=%h rise=%h, required ffff 0000", switches, sw_rise);
    end
  endtask

  task automatic test_single_rise();
    reset_dut(16'h0000);
    wait_cyc(1);
    sw_raw = 16'h0001;
    wait_cyc(11);
    tests_run++;
    if (switches !== 16'h0000) begin
      tests_failed++;
      $display("FAIL single_early: sw=%h, required 0000", switches);
    end
    wait_cyc(12);
    tests_run++;
    if (switches !== 16'h0001 || sw_rise !== 16'h0001 || sw_fall !== 16'h0000) begin
      tests_failed++;
      $display("FAIL single_accept: sw=%h rise=%h fall=%h, required 0001 0001 0000",
               switches, sw_rise, sw_fall);
    end
    wait_cyc(14);
    tests_run++;
    if (rise_cnt[0] != 1 || fall_cnt[0] != 0 || sw_rise !== 16'h0000) begin
      tests_failed++;
      $display("FAIL single_pulses: rise_cnt=%0d fall_cnt=%0d rise=%h, required 1 0 0000",
               rise_cnt[0], fall_cnt[0], sw_rise);
    end
  endtask

  task automatic test_latency_max();
    reset_dut(16'h0000);
    wait_cyc(2);
    sw_raw = 16'h0002;
    wait_cyc(15);
    tests_run++;
    if (switches !== 16'h0000) begin
      tests_failed++;
      $display("FAIL latency_max_early: sw=%h, required 0000", switches);
    end
    wait_cyc(16);
    tests_run++;
    if (switches !== 16'h0002) begin
      tests_failed++;
      $display("FAIL latency_max_accept: sw=%h, required 0002", switches);
    end
  endtask

  task automatic test_bounce();
    reset_dut(16'h0000);
    wait_cyc(1);
    sw_raw = 16'h0008;
    wait_cyc(9);
    sw_raw = 16'h0000;
    wait_cyc(12);
    tests_run++;
    if (switches !== 16'h0000) begin
      tests_failed++;
      $display("FAIL bounce_rejected: sw=%h, required 0000", switches);
    end
    wait_cyc(13);
    sw_raw = 16'h0008;
    wait_cyc(23);
    tests_run++;
    if (switches !== 16'h0000) begin
      tests_failed++;
      $display("FAIL bounce_early: sw=%h, required 0000", switches);
    end
    wait_cyc(24);
    tests_run++;
    if (switches !== 16'h0008 || sw_rise !== 16'h0008) begin
      tests_failed++;
      $display("FAIL bounce_accept: sw=%h rise=%h, required 0008 0008", switches, sw_rise);
    end
    wait_cyc(26);
    tests_run++;
    if (rise_cnt[3] != 1) begin
      tests_failed++;
      $display("FAIL bounce_pulse_count: got %0d, required 1", rise_cnt[3]);
    end
  endtask

  task automatic test_multi();
    reset_dut(16'h00ff);
    wait_cyc(13);
    tests_run++;
    if (switches !== 16'h00ff) begin
      tests_failed++;
      $display("FAIL multi_setup: sw=%h, required 00ff", switches);
    end
    sw_raw = 16'h0f0f;
    wait_cyc(23);
    tests_run++;
    if (switches !== 16'h00ff) begin
      tests_failed++;
      $display("FAIL multi_early: sw=%h, required 00ff", switches);
    end
    wait_cyc(24);
    tests_run++;
    if (switches !== 16'h0f0f || sw_rise !== 16'h0f00 || sw_fall !== 16'h00f0) begin
      tests_failed++;
      $display("FAIL multi_accept: sw=%h rise=%h fall=%h, required 0f0f 0f00 00f0",
               switches, sw_rise, sw_fall);
    end
    wait_cyc(25);
    tests_run++;
    if (sw_rise !== 16'h0000 || sw_fall !== 16'h0000) begin
      tests_failed++;
      $display("FAIL multi_pulse_end: rise=%h fall=%h, required 0000 0000", sw_rise, sw_fall);
    end
  endtask

  task automatic test_flag();
    reset_dut(16'h0000);
    wait_cyc(1);
    sw_raw = 16'h0001;
    wait_cyc(11);
    clr_flag = 1'b1;
    wait_cyc(12);
    tests_run++;
    if (sw_changed !== 1'b1 || switches !== 16'h0001) begin
      tests_failed++;
      $display("FAIL flag_set_wins: chg=%b sw=%h, required 1 0001", sw_changed, switches);
    end
    wait_cyc(13);
    clr_flag = 1'b0;
    tests_run++;
    if (sw_changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL flag_clear: chg=%b, required 0", sw_changed);
    end
    wait_cyc(16);
    tests_run++;
    if (sw_changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL flag_stays_clear: chg=%b, required 0", sw_changed);
    end
  endtask

  task automatic test_async_reset();
    reset_dut(16'h0001);
    wait_cyc(13);
    sw_raw = 16'h0021;
    wait_cyc(21);
    tests_run++;
    if (switches !== 16'h0001 || sw_changed !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_pre: sw=%h chg=%b, required 0001 1", switches, sw_changed);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({switches, sw_rise, sw_fall, sw_changed} !== 49'd0) begin
      tests_failed++;
      $display("FAIL async_clear: sw=%h rise=%h fall=%h chg=%b, required all 0",
               switches, sw_rise, sw_fall, sw_changed);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_counts();
    wait_cyc(5);
    tests_run++;
    if (switches !== 16'h0000) begin
      tests_failed++;
      $display("FAIL async_no_partial: sw=%h, required 0000", switches);
    end
    wait_cyc(11);
    tests_run++;
    if (switches !== 16'h0000) begin
      tests_failed++;
      $display("FAIL async_early: sw=%h, required 0000", switches);
    end
    wait_cyc(12);
    tests_run++;
    if (switches !== 16'h0021 || sw_rise !== 16'h0021) begin
      tests_failed++;
      $display("FAIL async_reaccept: sw=%h rise=%h, required 0021 0021", switches, sw_rise);
    end
  endtask

  initial begin
    reset = 1'b0; sw_raw = 16'h0000; clr_flag = 1'b0;
    test_reset();
    test_single_rise();
    test_latency_max();
    test_bounce();
    test_multi();
    test_flag();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
